// File: rtl/inst_rom_server.sv
// Instruction ROM server: a LOAD phase fills memory, then a SERVE phase returns mem[ProgCtr] with one cycle of latency.
// Optional INST_ROM_PARITY_EN stores an even-parity bit per word and adds a sticky ParityErr output.
module inst_rom_server #(
  parameter int             A_W       = 10,
  parameter int             I_W       = 9,
  parameter int             DEPTH     = 1024,
  parameter logic [I_W-1:0] HALT_WORD = '1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [A_W-1:0] ProgCtr,
  input  logic           FetchReq,
  input  logic           LoadEn,
  input  logic [A_W-1:0] LoadAddr,
  input  logic [I_W-1:0] LoadData,
  input  logic           LoadDone,
  output logic           Ready,
  output logic [I_W-1:0] InstOut,
  output logic           InstValid,
  output logic [A_W:0]   LoadCount,
  output logic           LoadErr,
  output logic           FetchErr
`ifdef INST_ROM_PARITY_EN
  ,
  output logic           ParityErr
`endif
);

  localparam int             M_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [A_W:0]   DEPTH_L = (A_W+1)'(DEPTH);
  localparam logic [A_W:0]   CNT_MAX = '1;
`ifdef INST_ROM_PARITY_EN
  localparam int             S_W     = I_W + 1;
`else
  localparam int             S_W     = I_W;
`endif

  typedef enum logic {ST_LOAD, ST_SERVE} state_t;

  state_t         state, state_nxt;
  logic [S_W-1:0] mem [DEPTH];
  logic [S_W-1:0] wr_word;
  logic [S_W-1:0] rd_word;
  logic           load_ok;
  logic           load_bad;
  logic           fetch_go;
  logic           pc_ok;
  logic           addr_ok;

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Ready     = 1'b0;
    load_ok   = 1'b0;
    load_bad  = 1'b0;
    fetch_go  = 1'b0;
    pc_ok     = ({1'b0, ProgCtr} < DEPTH_L);
    addr_ok   = ({1'b0, LoadAddr} < DEPTH_L);
    case (state)
      ST_LOAD: begin
        // A write coinciding with LoadDone still lands before the switch.
        load_ok  = LoadEn && addr_ok;
        load_bad = LoadEn && !addr_ok;
        if (LoadDone) state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        Ready    = 1'b1;
        fetch_go = FetchReq;
        load_bad = LoadEn;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

`ifdef INST_ROM_PARITY_EN
  assign wr_word = {^LoadData, LoadData};
`else
  assign wr_word = LoadData;
`endif

  // Contents survive Reset so a program can be re-run without reloading.
  always_ff @(posedge Clk) begin
    if (load_ok && !Reset) mem[LoadAddr[M_W-1:0]] <= wr_word;
  end

  assign rd_word = mem[ProgCtr[M_W-1:0]];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      InstOut   <= '0;
      InstValid <= 1'b0;
      LoadCount <= '0;
      LoadErr   <= 1'b0;
      FetchErr  <= 1'b0;
    end else begin
      InstValid <= fetch_go;
      if (fetch_go) InstOut <= pc_ok ? rd_word[I_W-1:0] : HALT_WORD;
      if (load_ok && (LoadCount != CNT_MAX)) LoadCount <= LoadCount + 1'b1;
      if (load_bad) LoadErr <= 1'b1;
      if (fetch_go && !pc_ok) FetchErr <= 1'b1;
    end
  end

`ifdef INST_ROM_PARITY_EN
  always_ff @(posedge Clk) begin
    if (Reset) ParityErr <= 1'b0;
    else if (fetch_go && pc_ok && (^rd_word)) ParityErr <= 1'b1;
  end
`endif

endmodule

// File: doc/inst_rom_server.md
Name: inst_rom_server

Overview:
- Instruction-memory responder on the far end of the fetch interface: takes the program counter from the fetch stage and returns the addressed machine word one cycle later.
- Also holds the loader port used by the bench or boot logic to write machine code before execution.
- FSM-gated: loading and serving are mutually exclusive.
- Sits between the fetch stage and the decode stage.

Parameters:
- A_W, 10, address width; matches ProgCtr width.
- I_W, 9, instruction word width.
- DEPTH, 1024, words implemented; must be <= 2**A_W. Addresses >= DEPTH are out of range.
- HALT_WORD, all ones (I_W bits), word returned for out-of-range fetches.

Ports:
- Clk  in  1  clock; all state changes on posedge only.
- Reset  in  1  synchronous, active-high reset.
- ProgCtr  in  A_W  fetch address from the program counter.
- FetchReq  in  1  fetch request for ProgCtr this cycle.
- LoadEn  in  1  write strobe for the loader port.
- LoadAddr  in  A_W  loader write address.
- LoadData  in  I_W  loader write data.
- LoadDone  in  1  one-cycle pulse that ends loading.
- Ready  out  1  high in SERVE state.
- InstOut  out  I_W  fetched instruction; holds its value between fetches.
- InstValid  out  1  high for exactly one cycle per accepted fetch.
- LoadCount  out  A_W+1  number of accepted loader writes since reset; saturates at 2**(A_W+1)-1.
- LoadErr  out  1  sticky load-violation flag.
- FetchErr  out  1  sticky fetch-violation flag.

Behaviour:
- States: LOAD (reset state) and SERVE.
- Reset: state LOAD; Ready=0, InstOut=0, InstValid=0, LoadCount=0, LoadErr=0, FetchErr=0.
- Memory contents are NOT cleared by reset. Reset mid-operation aborts any in-flight fetch: InstValid=0 on the next cycle.
- LOAD state:
  - LoadEn=1 with LoadAddr<DEPTH: word written at the edge; LoadCount increments.
  - LoadEn=1 with LoadAddr>=DEPTH: write dropped; LoadErr set.
  - FetchReq is ignored: no InstValid, no error.
  - LoadDone=1 moves to SERVE at the edge. If LoadEn is also high that cycle, the write is still performed first.
- SERVE state:
  - Ready=1.
  - FetchReq=1 at edge N: InstOut = mem[ProgCtr] and InstValid=1 during cycle N+1 (latency 1). Back-to-back requests give one word per cycle.
  - ProgCtr>=DEPTH: InstOut=HALT_WORD, InstValid=1, FetchErr set.
  - FetchReq=0: InstValid=0 next cycle; InstOut holds.
  - LoadEn=1: write blocked (write-protect); LoadErr set; LoadCount unchanged.
  - LoadDone: ignored.
  - Leaves SERVE only via Reset.
- Read-during-load hazard cannot occur, since the two states are exclusive.
- LoadCount saturates; it does not wrap.
- LoadErr and FetchErr clear only on Reset.

Optional Feature:
- Macro INST_ROM_PARITY_EN.
- Defined:
  - An even-parity bit is stored alongside each word on load.
  - On every fetch the parity is recomputed, and an extra output ParityErr (1 bit) is asserted together with InstValid when there is a mismatch.
  - ParityErr is a sticky flag cleared by Reset.
  - Out-of-range fetches never set ParityErr.
  - A bench backdoor-corrupts memory to exercise this path.
- Undefined: no parity storage and no ParityErr port; all other behaviour identical.

Test Plan:
- Reset, load mem[0..3]=9'h101,9'h0A2,9'h1FF,9'h003, then pulse LoadDone -> LoadCount=4, Ready=1 on the cycle after the LoadDone edge.
- SERVE: FetchReq=1 with ProgCtr=0,1,2,3 on consecutive cycles -> InstOut=101,0A2,1FF,003 with InstValid=1 on cycles N+1..N+4, then InstValid=0.
- DEPTH=512 build: fetch ProgCtr=600 -> InstOut=9'h1FF, InstValid=1, FetchErr=1 and it stays 1. Also load LoadAddr=700 in LOAD -> LoadErr=1, LoadCount unchanged.
- In SERVE, LoadEn=1 to address 0 with data 9'h055, then fetch 0 -> InstOut=9'h101 (write blocked), LoadErr=1.
- Assert Reset during a FetchReq cycle -> next cycle InstValid=0, Ready=0, flags=0. Then LoadDone and fetch 1 -> InstOut=9'h0A2 (memory retained).
- FetchReq in LOAD state with ProgCtr=2 -> no InstValid, InstOut remains 0. Also LoadEn and LoadDone in the same cycle -> write counted and Ready=1 next cycle.
